// File: rtl/core_hazard_ctrl_if.sv
// Pipeline <-> hazard control bundle: ID/EX/MEM status in, IF/ID/EX steering out.
interface core_hazard_ctrl_if #(
  parameter int unsigned RF_AW = 4
);
  logic             rfa_r;
  logic             rfb_r;
  logic [RF_AW-1:0] rfa_addr;
  logic [RF_AW-1:0] rfb_addr;
  logic             ex_wr;
  logic [RF_AW-1:0] ex_waddr;
  logic             ex_load;
  logic             mem_wr;
  logic [RF_AW-1:0] mem_waddr;
  logic             ex_multi;
  logic             ex_div;
  logic             branch_taken;
  logic             exc_req;
  logic             if_halt;
  logic             id_halt;
  logic             id_flush;
  logic             ex_bubble;
  logic             ex_stall;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             exc_ack;

  modport master (
    output rfa_r, rfb_r, rfa_addr, rfb_addr, ex_wr, ex_waddr, ex_load,
           mem_wr, mem_waddr, ex_multi, ex_div, branch_taken, exc_req,
    input  if_halt, id_halt, id_flush, ex_bubble, ex_stall, fwd_a, fwd_b, exc_ack
  );

  modport slave (
    input  rfa_r, rfb_r, rfa_addr, rfb_addr, ex_wr, ex_waddr, ex_load,
           mem_wr, mem_waddr, ex_multi, ex_div, branch_taken, exc_req,
    output if_halt, id_halt, id_flush, ex_bubble, ex_stall, fwd_a, fwd_b, exc_ack
  );
endinterface

// File: rtl/core_hazard_ctrl.sv
// Pipeline hazard/stall/flush control for IF/ID/EX/MEM.
// Optional CORE_HZ_FWD_EN: EX/MEM operand forwarding, stalls only on load-use.
module core_hazard_ctrl #(
  parameter int unsigned RF_AW      = 4,
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 16,
  parameter int unsigned CNT_W      = 5
) (
  input logic               clk,
  input logic               rst,
  core_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN = 2'd0, MULT = 2'd1, EXC = 2'd2} state_t;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [RF_AW-1:0] a_addr, b_addr, x_addr, m_addr;
  logic             hitx_a, hitx_b, hitm_a, hitm_b, hazard;
  logic [1:0]       fwd_a, fwd_b;
  logic             if_halt, id_halt, id_flush, ex_bubble, ex_stall, exc_ack;

  assign a_addr = hz.rfa_addr;
  assign b_addr = hz.rfb_addr;
  assign x_addr = hz.ex_waddr;
  assign m_addr = hz.mem_waddr;

  assign hitx_a = hz.rfa_r && hz.ex_wr  && (a_addr == x_addr);
  assign hitx_b = hz.rfb_r && hz.ex_wr  && (b_addr == x_addr);
  assign hitm_a = hz.rfa_r && hz.mem_wr && (a_addr == m_addr);
  assign hitm_b = hz.rfb_r && hz.mem_wr && (b_addr == m_addr);

  // Operand source select and RAW stall condition
  always_comb begin
`ifdef CORE_HZ_FWD_EN
    fwd_a  = hitx_a ? 2'b01 : (hitm_a ? 2'b10 : 2'b00);
    fwd_b  = hitx_b ? 2'b01 : (hitm_b ? 2'b10 : 2'b00);
    hazard = hz.ex_load && (hitx_a || hitx_b);
`else
    fwd_a  = 2'b00;
    fwd_b  = 2'b00;
    hazard = hitx_a || hitx_b || hitm_a || hitm_b;
`endif
  end

  // Next state and control outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    if_halt   = 1'b0;
    id_halt   = 1'b0;
    id_flush  = 1'b0;
    ex_bubble = 1'b0;
    ex_stall  = 1'b0;
    exc_ack   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (hz.branch_taken) begin
          id_flush  = 1'b1;
          ex_bubble = 1'b1;
        end else if (hz.ex_multi) begin
          cnt_d = hz.ex_div ? DIV_LAST : MUL_LAST;
          if (cnt_d != '0) begin
            if_halt  = 1'b1;
            id_halt  = 1'b1;
            ex_stall = 1'b1;
          end
          // A two-cycle op is fully covered by this cycle's stall.
          if (cnt_d > CNT_ONE) state_d = MULT;
        end else if (hz.exc_req) begin
          if_halt   = 1'b1;
          ex_bubble = 1'b1;
          cnt_d     = CNT_ONE;
          state_d   = EXC;
        end else if (hazard) begin
          if_halt   = 1'b1;
          id_halt   = 1'b1;
          ex_bubble = 1'b1;
        end
      end
      MULT: begin
        if_halt  = 1'b1;
        id_halt  = 1'b1;
        ex_stall = 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_TWO) state_d = RUN;
      end
      EXC: begin
        if_halt   = 1'b1;
        ex_bubble = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          exc_ack = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Everything is forced quiet while reset is held
  assign hz.if_halt   = !rst && if_halt;
  assign hz.id_halt   = !rst && id_halt;
  assign hz.id_flush  = !rst && id_flush;
  assign hz.ex_bubble = !rst && ex_bubble;
  assign hz.ex_stall  = !rst && ex_stall;
  assign hz.exc_ack   = !rst && exc_ack;
  assign hz.fwd_a     = rst ? 2'b00 : fwd_a;
  assign hz.fwd_b     = rst ? 2'b00 : fwd_b;

endmodule
